// File: rtl/mc_pkg.sv
// mc_pkg: shared state, opcode, instruction-class and writeback-select encodings
// for the multi-cycle control FSM.
package mc_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_FETCH  = 3'd0;
  localparam state_t S_DECODE = 3'd1;
  localparam state_t S_EXEC   = 3'd2;
  localparam state_t S_MEM    = 3'd3;
  localparam state_t S_WB     = 3'd4;
  localparam state_t S_HALT   = 3'd5;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  typedef enum logic [2:0] {C_ILLEGAL, C_R, C_ADDI, C_LW, C_SW, C_BEQ, C_JALR} opclass_e;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
endpackage

// File: rtl/mc_opclass_decode.sv
// mc_opclass_decode: combinational opcode -> instruction class map.
// Ports: opcode_i (inst[6:0]), op_class_o (class, C_ILLEGAL for anything unknown).
module mc_opclass_decode
  import mc_pkg::*;
(
  input  logic [6:0] opcode_i,
  output opclass_e   op_class_o
);
  always_comb
    op_class_o = opcode_i == OP_R    ? C_R    :
                 opcode_i == OP_ADDI ? C_ADDI :
                 opcode_i == OP_LW   ? C_LW   :
                 opcode_i == OP_SW   ? C_SW   :
                 opcode_i == OP_BEQ  ? C_BEQ  :
                 opcode_i == OP_JALR ? C_JALR : C_ILLEGAL;
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle processor control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Inputs : clk, rst (sync, active-low), opcode, br_eq, mem_ready.
// Outputs: pc_we, pc_sel, ir_we, mem_req, mem_we, mem_addr_sel, reg_we, wb_sel,
//          alu_src1, alu_src2, retired, trap, state.
// Config : MC_CTRL_ILLEGAL_TRAP_EN makes illegal opcodes halt with trap=1;
//          otherwise they retire as NOPs and trap is constant 0.
module mc_ctrl_fsm
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       br_eq,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       pc_sel,
  output logic       ir_we,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       alu_src1,
  output logic       alu_src2,
  output logic       retired,
  output logic       trap,
  output logic [2:0] state
);
  state_t   state_q, state_d;
  opclass_e class_q, class_d, dec_class;
  mc_opclass_decode u_dec (.opcode_i(opcode), .op_class_o(dec_class));
  // All outputs are forced low while reset is held, so a reset landing
  // mid-instruction can never leak a write strobe.
  always_comb begin
    state_d      = state_q;
    class_d      = class_q;
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    ir_we        = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    alu_src1     = 1'b0;
    alu_src2     = 1'b0;
    retired      = 1'b0;
    trap         = 1'b0;
    state        = rst ? state_q : S_FETCH;
    if (rst) begin
      if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
        alu_src1 = class_q == C_BEQ;
        alu_src2 = class_q != C_R;
      end
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
          state_d = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          class_d = dec_class;
          state_d = S_EXEC;
          if (dec_class == C_ILLEGAL) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            state_d = S_HALT;
`else
            pc_we   = 1'b1;
            retired = 1'b1;
            state_d = S_FETCH;
`endif
          end
        end
        S_EXEC: begin
          pc_we   = class_q == C_BEQ;
          pc_sel  = class_q == C_BEQ && br_eq;
          retired = class_q == C_BEQ;
          state_d = class_q == C_BEQ ? S_FETCH :
                    (class_q == C_LW || class_q == C_SW) ? S_MEM : S_WB;
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = class_q == C_SW;
          pc_we        = mem_ready && class_q == C_SW;
          retired      = mem_ready && class_q == C_SW;
          state_d      = !mem_ready ? S_MEM : class_q == C_SW ? S_FETCH : S_WB;
        end
        S_WB: begin
          reg_we  = 1'b1;
          wb_sel  = class_q == C_LW ? WB_MEM : class_q == C_JALR ? WB_PC4 : WB_ALU;
          pc_we   = 1'b1;
          pc_sel  = class_q == C_JALR;
          retired = 1'b1;
          state_d = S_FETCH;
        end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        S_HALT: trap = 1'b1;
`endif
        default: state_d = S_FETCH;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state_q <= S_FETCH;
      class_q <= C_ILLEGAL;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
    end
endmodule
